// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: two request channels and one response channel for the shared ALU
interface alu_share_arbiter_if #(parameter int width = 32);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [width-1:0] req0_a;
    logic [width-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [width-1:0] req1_a;
    logic [width-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [width-1:0] rsp_y;
    logic             rsp_zero;
    logic             rsp_illegal;
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_illegal
    );
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered ALU between two valid/ready requesters
module alu_share_arbiter #(
    parameter int width = 32,
    parameter int shw   = $clog2(width)
) (
    input logic clk,
    input logic rst_n,
    alu_share_arbiter_if.slave bus
);
    logic             prio;
    logic             grant;
    logic             any;
    logic             can_accept;
    logic             accept;
    logic             illegal;
    logic [3:0]       op;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic [width-1:0] y;
    logic [shw-1:0]   sh;
    // Ready is gated by rst_n so nothing is accepted while reset is held
    always_comb begin
        can_accept     = !bus.rsp_valid || bus.rsp_ready;
        any            = bus.req0_valid || bus.req1_valid;
        grant          = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
        bus.req0_ready = rst_n && can_accept && any && !grant;
        bus.req1_ready = rst_n && can_accept && any && grant;
        accept         = bus.req0_ready || bus.req1_ready;
        op             = grant ? bus.req1_op : bus.req0_op;
        a              = grant ? bus.req1_a : bus.req0_a;
        b              = grant ? bus.req1_b : bus.req0_b;
        sh             = b[shw-1:0];
    end
    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            4'b0000: y = a & b;
            4'b0001: y = a | b;
            4'b0010: y = a + b;
            4'b0110: y = a - b;
            4'b0011: y = a << sh;
            4'b0100: y = {{(width-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0101: y = {{(width-1){1'b0}}, a < b};
            4'b0111: y = a ^ b;
            4'b1000: y = a >> sh;
            4'b1010: y = $signed(a) >>> sh;
            default: illegal = 1'b1;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_y       <= '0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_illegal <= 1'b0;
            prio            <= 1'b0;
        end else if (accept) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_id      <= grant;
            bus.rsp_y       <= y;
            bus.rsp_zero    <= (y == '0);
            bus.rsp_illegal <= illegal;
            prio            <= !grant;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with a response scoreboard for alu_share_arbiter
module tb_alu_share_arbiter;
    localparam int W = 32;
    typedef struct packed {
        logic         id;
        logic [W-1:0] y;
        logic         zero;
        logic         illegal;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.width(W)) bus();
    alu_share_arbiter #(.width(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    rsp_t q[$];
    rsp_t mon_e, mon_g;
    int vectors = 0;
    int errors = 0;

    logic [3:0]   c_op [10] = '{4'b1010, 4'b0100, 4'b0101, 4'b0011, 4'b1000,
                                4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    logic [W-1:0] c_a  [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'h0, 32'hF0F0, 32'hF0F0, 32'hAAAA_5555};
    logic [W-1:0] c_b  [10] = '{32'h24, 32'h1, 32'h1, 32'd31, 32'h4,
                                32'h1, 32'h1, 32'hFF00, 32'h0F00, 32'hFFFF_0000};
    logic [W-1:0] c_y  [10] = '{32'hF800_0000, 32'h1, 32'h0, 32'h8000_0000, 32'h0800_0000,
                                32'h0, 32'hFFFF_FFFF, 32'hF000, 32'hFFF0, 32'h5555_5555};

    function automatic rsp_t r(input logic id, input logic [W-1:0] y, input logic ill);
        return {id, y, (y == '0), ill};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req0_valid = v;
        bus.req0_op    = op;
        bus.req0_a     = a;
        bus.req0_b     = b;
    endtask

    task automatic set1(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req1_valid = v;
        bus.req1_op    = op;
        bus.req1_a     = a;
        bus.req1_b     = b;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            mon_g = {bus.rsp_id, bus.rsp_y, bus.rsp_zero, bus.rsp_illegal};
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d y=%h want no response", mon_g.id, mon_g.y);
            end else begin
                mon_e = q.pop_front();
                if (mon_g !== mon_e) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d y=%h z=%b ill=%b want id=%0d y=%h z=%b ill=%b",
                             mon_g.id, mon_g.y, mon_g.zero, mon_g.illegal,
                             mon_e.id, mon_e.y, mon_e.zero, mon_e.illegal);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.rsp_ready = 1'b1;
        set0(1'b1, 4'b0010, 32'd5, 32'd7);
        set1(1'b1, 4'b0010, 32'd1, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_y", bus.rsp_y, 0);
        chk("rst_rsp_zero", bus.rsp_zero, 0);
        chk("rst_rsp_illegal", bus.rsp_illegal, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        set0(1'b0, 4'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("req1_alone_ready", bus.req1_ready, 1);
        chk("req0_idle_ready", bus.req0_ready, 0);
        q.push_back(r(1'b1, 32'd2, 1'b0));
        tick();
        set1(1'b0, 4'b0, 32'd0, 32'd0);
        set0(1'b1, 4'b0010, 32'd5, 32'd7);
        q.push_back(r(1'b0, 32'd12, 1'b0));
        #1;
        chk("add_req0_ready", bus.req0_ready, 1);
        tick();
        set0(1'b0, 4'b0, 32'd0, 32'd0);
        chk("add_rsp_valid", bus.rsp_valid, 1);
        tick();
        chk("drain_rsp_valid", bus.rsp_valid, 0);
        // prio is 1 after the last req0 grant, so alternation starts with requester 1
        set0(1'b1, 4'b0110, 32'd3, 32'd3);
        set1(1'b1, 4'b0111, 32'hF0, 32'h0F);
        q.push_back(r(1'b1, 32'hFF, 1'b0));
        q.push_back(r(1'b0, 32'h0, 1'b0));
        q.push_back(r(1'b1, 32'hFF, 1'b0));
        q.push_back(r(1'b0, 32'h0, 1'b0));
        repeat (4) tick();
        set0(1'b0, 4'b0110, 32'd3, 32'd3);
        set1(1'b0, 4'b0111, 32'hF0, 32'h0F);
        tick();
        bus.rsp_ready = 1'b0;
        set0(1'b1, 4'b0110, 32'd3, 32'd3);
        set1(1'b1, 4'b0111, 32'hF0, 32'h0F);
        q.push_back(r(1'b1, 32'hFF, 1'b0));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_req0_ready", bus.req0_ready, 0);
            chk("bp_req1_ready", bus.req1_ready, 0);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_y", bus.rsp_y, 32'hFF);
            chk("bp_rsp_id", bus.rsp_id, 1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        q.push_back(r(1'b0, 32'h0, 1'b0));
        #1;
        chk("bp_release_req0_ready", bus.req0_ready, 1);
        chk("bp_release_req1_ready", bus.req1_ready, 0);
        tick();
        set0(1'b0, 4'b0, 32'd0, 32'd0);
        set1(1'b0, 4'b0, 32'd0, 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set0(1'b1, c_op[i], c_a[i], c_b[i]);
            q.push_back(r(1'b0, c_y[i], 1'b0));
            tick();
        end
        set0(1'b0, 4'b0, 32'd0, 32'd0);
        tick();
        // illegal op from req0 leaves prio=1, so the reset must be what restores req0 priority
        bus.rsp_ready = 1'b0;
        set0(1'b1, 4'b1111, 32'd123, 32'd456);
        tick();
        set0(1'b0, 4'b0, 32'd0, 32'd0);
        chk("ill_rsp_valid", bus.rsp_valid, 1);
        chk("ill_rsp_y", bus.rsp_y, 0);
        chk("ill_rsp_illegal", bus.rsp_illegal, 1);
        chk("ill_rsp_zero", bus.rsp_zero, 1);
        chk("ill_rsp_id", bus.rsp_id, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_rsp_illegal", bus.rsp_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        set0(1'b1, 4'b0010, 32'd5, 32'd7);
        set1(1'b1, 4'b0010, 32'd1, 32'd1);
        #1;
        chk("postrst_req0_ready", bus.req0_ready, 1);
        chk("postrst_req1_ready", bus.req1_ready, 0);
        q.push_back(r(1'b0, 32'd12, 1'b0));
        tick();
        set0(1'b0, 4'b0, 32'd0, 32'd0);
        set1(1'b0, 4'b0, 32'd0, 32'd0);
        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
